hp_bytequad_sync: RTL

Host-to-parasite half of the Tube register file, as four byte channels in one clock domain.
- Host writes R1..R4; parasite reads them.
- R1, R2 and R4 are single-byte holding registers.
- R3 is a small FIFO with one-byte/two-byte mode.
- Sits beside the parasite-to-host byte quad. It supplies the parasite read data mux, the per-channel data-available flags and the host-side full flags.

---
 rtl/hp_pkg.sv | 18 +
 rtl/hp_byte_sync.sv | 46 ++++
 rtl/hp_bytequad_sync.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/hp_pkg.sv
// Shared constants and helpers for the host/parasite byte-quad register files.
package hp_pkg;

    localparam int unsigned NUM_CH       = 4;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned R3_DEPTH_DEF = 2;

    localparam int unsigned R1_IDX = 0;
    localparam int unsigned R2_IDX = 1;
    localparam int unsigned R3_IDX = 2;
    localparam int unsigned R4_IDX = 3;

    // Isolate the lowest set bit; yields all-zero when nothing is selected.
    function automatic logic [NUM_CH-1:0] lowest_set(input logic [NUM_CH-1:0] vec);
        return vec & (~vec + NUM_CH'(1));
    endfunction

endpackage

// File: rtl/hp_byte_sync.sv
// Single-byte holding register: valid doubles as the full flag; a write while
// full is accepted only when the same cycle pops the byte out.
module hp_byte_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             pop_ok_c, push_ok_c;

    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        pop_ok_c  = pop && valid_q;
        push_ok_c = push && (!valid_q || pop_ok_c);
        if (pop_ok_c) begin
            valid_d = 1'b0;
        end
        if (push_ok_c) begin
            valid_d = 1'b1;
            data_d  = din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/hp_bytequad_sync.sv
// Host-to-parasite byte quad: R1/R2/R4 holding registers, R3 FIFO, parasite read mux.
// Optional interrupt outputs built when HP_BYTEQUAD_IRQ_EN is defined.
module hp_bytequad_sync #(
    parameter int unsigned R3_DEPTH = hp_pkg::R3_DEPTH_DEF,
    parameter int unsigned DATA_W   = hp_pkg::DATA_W
) (
    input  logic              h_phi2,
    input  logic              h_rst,
    input  logic              h_wr,
    input  logic [3:0]        h_selectData,
    input  logic [DATA_W-1:0] h_data,
    input  logic              p_rd,
    input  logic [3:0]        p_selectData,
    input  logic              one_byte_mode,
    output logic [DATA_W-1:0] p_data,
    output logic [3:0]        p_data_available,
    output logic              p_zero_bytes_available,
`ifdef HP_BYTEQUAD_IRQ_EN
    input  logic              irq_en_r1,
    input  logic              irq_en_r4,
    input  logic              nmi_en_r3,
    output logic              p_irq,
    output logic              p_nmi,
`endif
    output logic [3:0]        h_full
);

    import hp_pkg::*;

    localparam int unsigned PTR_W = (R3_DEPTH > 2) ? 2 : 1;
    localparam int unsigned CNT_W = (R3_DEPTH > 3) ? 3 : 2;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(R3_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(R3_DEPTH);

    logic [3:0] h_sel_c, p_sel_c, push_c, pop_c;

    assign h_sel_c = lowest_set(h_selectData);
    assign p_sel_c = lowest_set(p_selectData);
    assign push_c  = h_sel_c & {4{h_wr}};
    assign pop_c   = p_sel_c & {4{p_rd}};

    // Single-byte channels
    logic              r1_valid, r2_valid, r4_valid;
    logic [DATA_W-1:0] r1_data, r2_data, r4_data;

    hp_byte_sync #(.WIDTH(DATA_W)) u_r1 (
        .clk   (h_phi2),
        .rst   (h_rst),
        .push  (push_c[R1_IDX]),
        .pop   (pop_c[R1_IDX]),
        .din   (h_data),
        .valid (r1_valid),
        .dout  (r1_data)
    );

    hp_byte_sync #(.WIDTH(DATA_W)) u_r2 (
        .clk   (h_phi2),
        .rst   (h_rst),
        .push  (push_c[R2_IDX]),
        .pop   (pop_c[R2_IDX]),
        .din   (h_data),
        .valid (r2_valid),
        .dout  (r2_data)
    );

    hp_byte_sync #(.WIDTH(DATA_W)) u_r4 (
        .clk   (h_phi2),
        .rst   (h_rst),
        .push  (push_c[R4_IDX]),
        .pop   (pop_c[R4_IDX]),
        .din   (h_data),
        .valid (r4_valid),
        .dout  (r4_data)
    );

    // R3 circular FIFO
    logic [DATA_W-1:0] mem_q [R3_DEPTH];
    logic [DATA_W-1:0] mem_d [R3_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  cap_c;
    logic              r3_full_c, r3_avail_c, r3_pop_ok_c, r3_push_ok_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        cap_c        = one_byte_mode ? CNT_W'(1) : CNT_MAX;
        r3_full_c    = (count_q >= cap_c);
        r3_avail_c   = one_byte_mode ? (count_q != '0) : (count_q == CNT_MAX);
        r3_pop_ok_c  = pop_c[R3_IDX] && (count_q != '0);
        // A full FIFO (even over-full after a mode switch) takes a byte only in a pop cycle.
        r3_push_ok_c = push_c[R3_IDX] && (!r3_full_c || r3_pop_ok_c);

        if (r3_push_ok_c) begin
            mem_d[wr_ptr_q] = h_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (r3_pop_ok_c) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({r3_push_ok_c, r3_pop_ok_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge h_phi2) begin
        if (h_rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Flags and parasite read mux; empty or unselected channels read as zero
    assign p_data_available       = {r4_valid, r3_avail_c, r2_valid, r1_valid};
    assign h_full                 = {r4_valid, r3_full_c, r2_valid, r1_valid};
    assign p_zero_bytes_available = (count_q == '0);

    always_comb begin
        p_data = '0;
        if (p_sel_c[R1_IDX] && r1_valid) begin
            p_data = r1_data;
        end
        if (p_sel_c[R2_IDX] && r2_valid) begin
            p_data = r2_data;
        end
        if (p_sel_c[R3_IDX] && (count_q != '0)) begin
            p_data = mem_q[rd_ptr_q];
        end
        if (p_sel_c[R4_IDX] && r4_valid) begin
            p_data = r4_data;
        end
    end

`ifdef HP_BYTEQUAD_IRQ_EN
    // Interrupt requests, one cycle behind the availability flags
    logic p_irq_q, p_irq_d, p_nmi_q, p_nmi_d;

    always_comb begin
        p_irq_d = (irq_en_r1 && r1_valid) || (irq_en_r4 && r4_valid);
        p_nmi_d = nmi_en_r3 && r3_avail_c;
    end

    always_ff @(posedge h_phi2) begin
        if (h_rst) begin
            p_irq_q <= 1'b0;
            p_nmi_q <= 1'b0;
        end else begin
            p_irq_q <= p_irq_d;
            p_nmi_q <= p_nmi_d;
        end
    end

    assign p_irq = p_irq_q;
    assign p_nmi = p_nmi_q;
`endif

endmodule
